// File: rtl/issue_stage_if.sv
// issue_stage_if: fetch, ALU-issue and writeback signals of the issue stage
interface issue_stage_if #(parameter int XLEN = 64);
  logic            in_valid;
  logic [31:0]     in_instr;
  logic            in_ready;
  logic            out_valid;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic            imm;
  logic [4:0]      out_rd;
  logic            illegal;
  logic            wb_en;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  modport master (
    output in_valid, in_instr, wb_en, wb_rd, wb_data,
    input  in_ready, out_valid, op1, op2, funct3, funct7, imm, out_rd, illegal
  );
  modport slave (
    input  in_valid, in_instr, wb_en, wb_rd, wb_data,
    output in_ready, out_valid, op1, op2, funct3, funct7, imm, out_rd, illegal
  );
endinterface

// File: rtl/issue_stage.sv
// issue_stage: OP/OP-IMM decode and issue with register file, writeback bypass and busy scoreboard
module issue_stage #(
  parameter int XLEN = 64,
  parameter int NREG = 32
) (
  input logic         CLK,
  input logic         RST,
  issue_stage_if.slave bus
);
  localparam logic [6:0] OPC_OP  = 7'b0110011;
  localparam logic [6:0] OPC_OPI = 7'b0010011;
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_ISSUE = 1'b1;
  logic [XLEN-1:0] r_regs [NREG];
  logic [NREG-1:0] r_busy;
  logic [0:0]      r_state;
  logic [XLEN-1:0] r_op1, r_op2;
  logic [2:0]      r_f3;
  logic [6:0]      r_f7;
  logic            r_imm, r_illegal;
  logic [4:0]      r_rd;
  logic [4:0]      w_rs1, w_rs2, w_rd;
  logic [2:0]      w_f3;
  logic            w_is_op, w_is_opi, w_legal, w_shift, w_hazard, w_accept;
  logic [NREG-1:0] w_wb_mask, w_set_mask, w_busy;
  logic [XLEN-1:0] w_rs1_val, w_rs2_val, w_op2;
  logic [6:0]      w_f7;
  assign w_rs1    = bus.in_instr[19:15];
  assign w_rs2    = bus.in_instr[24:20];
  assign w_rd     = bus.in_instr[11:7];
  assign w_f3     = bus.in_instr[14:12];
  assign w_is_op  = bus.in_instr[6:0] == OPC_OP;
  assign w_is_opi = bus.in_instr[6:0] == OPC_OPI;
  assign w_legal  = w_is_op || w_is_opi;
  assign w_shift  = w_is_opi && (w_f3 == 3'b001 || w_f3 == 3'b101);
  // A register whose writeback lands this cycle is already free; bit 0 is never set.
  assign w_wb_mask  = bus.wb_en ? (NREG'(1) << bus.wb_rd) : '0;
  assign w_busy     = r_busy & ~w_wb_mask;
  assign w_hazard   = w_legal && (w_busy[w_rs1] || (w_is_op && w_busy[w_rs2]) || w_busy[w_rd]);
  assign w_accept   = bus.in_valid && !w_hazard;
  assign w_set_mask = (w_accept && w_legal && w_rd != 5'd0) ? (NREG'(1) << w_rd) : '0;
  assign w_rs1_val  = (w_rs1 == 5'd0) ? '0 :
                      (bus.wb_en && bus.wb_rd == w_rs1) ? bus.wb_data : r_regs[w_rs1];
  assign w_rs2_val  = (w_rs2 == 5'd0) ? '0 :
                      (bus.wb_en && bus.wb_rd == w_rs2) ? bus.wb_data : r_regs[w_rs2];
  assign w_op2 = w_is_op ? w_rs2_val :
                 w_shift ? {{(XLEN-6){1'b0}}, bus.in_instr[25:20]} :
                           {{(XLEN-12){bus.in_instr[31]}}, bus.in_instr[31:20]};
  assign w_f7  = w_is_op ? bus.in_instr[31:25] :
                 w_shift ? {bus.in_instr[31:26], 1'b0} : 7'd0;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= S_IDLE;
      r_illegal <= 1'b0;
      r_op1     <= '0;
      r_op2     <= '0;
      r_f3      <= '0;
      r_f7      <= '0;
      r_imm     <= 1'b0;
      r_rd      <= '0;
      r_busy    <= '0;
    end else begin
      r_state   <= (w_accept && w_legal) ? S_ISSUE : S_IDLE;
      r_illegal <= w_accept && !w_legal;
      r_busy    <= (w_busy | w_set_mask) & ~NREG'(1);
      if (w_accept && w_legal) begin
        r_op1 <= w_rs1_val;
        r_op2 <= w_op2;
        r_f3  <= w_f3;
        r_f7  <= w_f7;
        r_imm <= w_is_opi;
        r_rd  <= w_rd;
      end
    end
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else if (bus.wb_en && bus.wb_rd != 5'd0) begin
      r_regs[bus.wb_rd] <= bus.wb_data;
    end
  end
  assign bus.in_ready  = !w_hazard;
  assign bus.out_valid = r_state == S_ISSUE;
  assign bus.illegal   = r_illegal;
  assign bus.op1       = r_op1;
  assign bus.op2       = r_op2;
  assign bus.funct3    = r_f3;
  assign bus.funct7    = r_f7;
  assign bus.imm       = r_imm;
  assign bus.out_rd    = r_rd;
endmodule

// File: tb/tb_issue_stage.sv
// tb_issue_stage: directed issue/writeback vectors with a queue scoreboard checked by a monitor
module tb_issue_stage;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  issue_stage_if #(.XLEN(64)) bus();
  issue_stage #(.XLEN(64), .NREG(32)) dut (.CLK(CLK), .RST(RST), .bus(bus));
  always #5 CLK = ~CLK;
  typedef struct {
    logic        ill;
    logic [63:0] op1;
    logic [63:0] op2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        imm;
    logic [4:0]  rd;
  } exp_t;
  exp_t q[$];
  int n_chk = 0;
  int n_fail = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask
  function automatic exp_t mk(input logic [63:0] a, input logic [63:0] b, input logic [2:0] f3,
                              input logic [6:0] f7, input logic imm, input logic [4:0] rd);
    exp_t e;
    e.ill = 1'b0; e.op1 = a; e.op2 = b; e.f3 = f3; e.f7 = f7; e.imm = imm; e.rd = rd;
    return e;
  endfunction
  function automatic exp_t mk_ill();
    exp_t e;
    e = mk(64'd0, 64'd0, 3'd0, 7'd0, 1'b0, 5'd0);
    e.ill = 1'b1;
    return e;
  endfunction
  always @(negedge CLK) begin
    exp_t e;
    if (!RST && (bus.out_valid || bus.illegal)) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_output: out_valid=%0b illegal=%0b with nothing expected at %0t",
                 bus.out_valid, bus.illegal, $time);
      end else begin
        e = q.pop_front();
        chk("illegal", {63'd0, bus.illegal}, {63'd0, e.ill});
        chk("out_valid", {63'd0, bus.out_valid}, {63'd0, !e.ill});
        if (!e.ill) begin
          chk("op1", bus.op1, e.op1);
          chk("op2", bus.op2, e.op2);
          chk("funct3", {61'd0, bus.funct3}, {61'd0, e.f3});
          chk("funct7", {57'd0, bus.funct7}, {57'd0, e.f7});
          chk("imm", {63'd0, bus.imm}, {63'd0, e.imm});
          chk("out_rd", {59'd0, bus.out_rd}, {59'd0, e.rd});
        end
      end
    end
  end
  task automatic send(input logic [31:0] instr, input exp_t e, input int exp_stall);
    int st = 0;
    bit done = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_instr = instr;
    while (!done && st < 40) begin
      @(negedge CLK);
      if (bus.in_ready) done = 1'b1;
      else st++;
    end
    if (!done) begin
      n_chk++;
      n_fail++;
      $display("FAIL accept_timeout: instr %08h not accepted after %0d cycles", instr, st);
      bus.in_valid = 1'b0;
    end else begin
      @(posedge CLK);
      #1;
      bus.in_valid = 1'b0;
      q.push_back(e);
      chk("stall_cycles", 64'(st), 64'(exp_stall));
    end
  endtask
  task automatic wb(input logic [4:0] rd, input logic [63:0] d);
    bus.wb_en   = 1'b1;
    bus.wb_rd   = rd;
    bus.wb_data = d;
    @(posedge CLK);
    #1;
    bus.wb_en = 1'b0;
  endtask
  task automatic send_wb(input logic [31:0] instr, input exp_t e, input int stalls,
                         input logic [4:0] rd, input logic [63:0] d);
    fork
      send(instr, e, stalls);
      begin
        repeat (stalls) begin
          @(negedge CLK);
          chk("stall_ready", {63'd0, bus.in_ready}, 64'd0);
        end
        @(posedge CLK);
        #1;
        wb(rd, d);
      end
    join
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.in_valid = 1'b0;
    bus.in_instr = 32'd0;
    bus.wb_en    = 1'b0;
    bus.wb_rd    = 5'd0;
    bus.wb_data  = 64'd0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_illegal", {63'd0, bus.illegal}, 64'd0);
    chk("rst_op1", bus.op1, 64'd0);
    chk("rst_op2", bus.op2, 64'd0);
    chk("rst_funct3", {61'd0, bus.funct3}, 64'd0);
    chk("rst_funct7", {57'd0, bus.funct7}, 64'd0);
    chk("rst_imm", {63'd0, bus.imm}, 64'd0);
    chk("rst_out_rd", {59'd0, bus.out_rd}, 64'd0);
    chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    @(posedge CLK);
    #1;
    wb(5'd1, 64'd5);
    wb(5'd2, 64'd7);
    send(32'h002081B3, mk(64'd5, 64'd7, 3'd0, 7'd0, 1'b0, 5'd3), 0);
    send(32'h4280D213, mk(64'd5, 64'd40, 3'd5, 7'h20, 1'b1, 5'd4), 0);
    send(32'hFFF00293, mk(64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 3'd0, 7'd0, 1'b1, 5'd5), 0);
    send_wb(32'h40118333, mk(64'd12, 64'd5, 3'd0, 7'h20, 1'b0, 5'd6), 3, 5'd3, 64'd12);
    send(32'h00000003, mk_ill(), 0);
    send(32'h00000383, mk_ill(), 0);
    send(32'h00038433, mk(64'd0, 64'd0, 3'd0, 7'd0, 1'b0, 5'd8), 0);
    send_wb(32'h00100213, mk(64'd0, 64'd1, 3'd0, 7'd0, 1'b1, 5'd4), 2, 5'd4, 64'd77);
    send(32'h00900013, mk(64'd0, 64'd9, 3'd0, 7'd0, 1'b1, 5'd0), 0);
    fork
      wb(5'd0, 64'd9);
      send(32'h000004B3, mk(64'd0, 64'd0, 3'd0, 7'd0, 1'b0, 5'd9), 0);
    join
    send(32'h00208533, mk(64'd5, 64'd7, 3'd0, 7'd0, 1'b0, 5'd10), 0);
    send(32'h001105B3, mk(64'd7, 64'd5, 3'd0, 7'd0, 1'b0, 5'd11), 0);
    bus.in_valid = 1'b1;
    bus.in_instr = 32'h40528633;
    repeat (2) begin
      @(negedge CLK);
      chk("busy_x5_ready", {63'd0, bus.in_ready}, 64'd0);
    end
    @(posedge CLK);
    #1;
    RST = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge CLK);
    chk("midrst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("midrst_illegal", {63'd0, bus.illegal}, 64'd0);
    chk("midrst_op1", bus.op1, 64'd0);
    chk("midrst_out_rd", {59'd0, bus.out_rd}, 64'd0);
    @(posedge CLK);
    #1 RST = 1'b0;
    send(32'h002086B3, mk(64'd0, 64'd0, 3'd0, 7'd0, 1'b0, 5'd13), 0);
    send(32'h40528633, mk(64'd0, 64'd0, 3'd0, 7'h20, 1'b0, 5'd12), 0);
    repeat (3) @(posedge CLK);
    #1;
    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
